fight_arena: RTL
================

# fight_arena

Parametrised two-player fight engine, the next generation of the game-logic core. It tracks arena positions, HP, regeneration, attack cooldowns and multi-round match scoring for two players. It sits between the debounced player-input decoder and the display/scoreboard drivers. All outputs are registered.

## Interface
- NUM_POS, 5, positions per player, counted as distance from centre line, 1..NUM_POS (≥2)
- MAX_HP, 4, starting and maximum HP (≥1)
- PUNCH_DMG, 2, HP removed by a landed punch
- KICK_DMG, 1, HP removed by a landed kick
- REGEN_WAIT, 2, consecutive wait cycles per +1 HP (≥1)
- COOLDOWN, 2, enabled cycles an attacker is locked out after an attack attempt (0 = none)
- ROUNDS_TO_WIN, 2, round wins that end the match
- ROUND_PAUSE, 4, enabled cycles of round_over before the next round
- Derived localparams (not overridable): POS_W=$clog2(NUM_POS+1), HP_W=$clog2(MAX_HP+1), WIN_W=$clog2(ROUNDS_TO_WIN+1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- en  in  1  advance enable; low freezes all state
- act1  in  6  player 1 {punch,kick,wait,jump,left,right}, bit5..bit0
- act2  in  6  player 2, same mapping
- pos1, pos2  out  POS_W  current distance from centre
- pos1_oh, pos2_oh  out  NUM_POS  one-hot position, bit (pos-1)
- hp1, hp2  out  HP_W  current HP
- wins1, wins2  out  WIN_W  rounds won
- round_over  out  1  high during ROUND_END
- match_over  out  1  high in MATCH_OVER
- winner  out  2  01 = P1, 10 = P2, 00 = none/draw

## Operation
- States: FIGHT, ROUND_END, MATCH_OVER. Reset lands in FIGHT.
- Reset values: pos=NUM_POS, hp=MAX_HP, wins=0, rest/cooldown/pause counters=0, round_over=0, match_over=0, winner=00.
- reset beats en in every state. en=0 holds all registers, including the pause counter.
- FIGHT cycle with en=1 runs these steps in order. Each step uses the results of the previous one.
  1. Move. P1: left = away (+1, saturate NUM_POS), right = toward (−1, saturate 1). P2 is mirrored: left = toward, right = away. left and right together: no move.
  2. Wait. wait with no attack bit: rest counter +1. When it reaches REGEN_WAIT: hp+1 (saturate MAX_HP) and counter clears. wait low clears counter. While wait is high, punch/kick are ignored and cooldown is not loaded.
  3. Attack. gap = pos1+pos2, computed at POS_W+1 bits. Punch range is gap==2. Kick range is gap 2 or 3. Punch has priority over kick within one player. An attempt requires cooldown==0 and loads cooldown=COOLDOWN, whether it hits or misses. Nonzero cooldown decrements every enabled cycle.
  4. Clash. Both punch at gap 2, or both kick at gap 3 (both attempts valid): each pos +1 (saturate), no damage.
  5. Otherwise each valid in-range attack lands unless the defender has jump set. Both players may land in the same cycle. Damage saturates at 0.
  6. Round check. Exactly one hp==0: winner's wins +1. Then if wins==ROUNDS_TO_WIN, go to MATCH_OVER and set winner; else go to ROUND_END. Both 0 (double KO): no wins change, go to ROUND_END.
- ROUND_END: round_over=1. Inputs are ignored. After ROUND_PAUSE enabled cycles: pos, hp, rest and cooldown return to reset values, go to FIGHT. wins are kept.
- MATCH_OVER: all inputs ignored, outputs frozen until reset.

## Timing
- Inputs are sampled at edge N. Results are visible after edge N; no other latency.
- Attack accepted at edge N: the next accepted attack is at edge N+COOLDOWN+1 at the earliest.
- Regen with wait held from edge N: hp increments at edges N+REGEN_WAIT−1, N+2·REGEN_WAIT−1, and so on.
- Round-ending hit at edge N: round_over high after N, for ROUND_PAUSE enabled edges. FIGHT resumes after edge N+ROUND_PAUSE (en continuously high); hp/pos show reset values from that point.
- match_over and winner assert in the same cycle as the final hp update.

## Test plan
(Default parameters throughout.)
- Movement: from reset, act1=right and act2=left for 4 cycles → pos1=pos2=1, pos1_oh=00001. A 5th cycle holds at 1. left+right together → unchanged. act1=left 5 cycles → saturates at 5.
- Punch/cooldown/jump: at gap 2, punch1 held 4 cycles → hp2 4→2 after the first edge, next hit after the 4th edge → 0. Separately: punch1 with jump2 → hp2 unchanged, cooldown1 loaded to 2.
- Clash and trade: both punch at pos 1/1 → pos 2/2, hp 4/4. Punch1+kick2 at gap 2 → hp2=2, hp1=3.
- Regen: hp1=2, wait1 held 5 cycles → hp1=3 after the 2nd edge, 4 after the 4th, stays 4. Pattern wait, idle, wait → no gain.
- Rounds: KO P2 → wins1=1, round_over high exactly 4 cycles, then hp 4/4, pos 5/5. Second KO → match_over=1, winner=01, inputs ignored. Double KO → wins unchanged, winner=00.
- Reset/enable: en=0 mid-ROUND_END freezes the pause count. reset during ROUND_END, during MATCH_OVER, and with en=0 → every output at its reset value after one edge.

Source files
------------

// File: rtl/fight_arena.sv
// fight_arena: two-player fight engine (movement, HP/regen, attack cooldowns, round and match scoring).
// Every output is registered and reflects the inputs sampled at the previous edge; there is no backpressure, and en=0 freezes all state.
module fight_arena #(
  parameter int NUM_POS       = 5,
  parameter int MAX_HP        = 4,
  parameter int PUNCH_DMG     = 2,
  parameter int KICK_DMG      = 1,
  parameter int REGEN_WAIT    = 2,
  parameter int COOLDOWN      = 2,
  parameter int ROUNDS_TO_WIN = 2,
  parameter int ROUND_PAUSE   = 4,
  localparam int POS_W = $clog2(NUM_POS + 1),
  localparam int HP_W  = $clog2(MAX_HP + 1),
  localparam int WIN_W = $clog2(ROUNDS_TO_WIN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [5:0]         act1,
  input  logic [5:0]         act2,
  output logic [POS_W-1:0]   pos1,
  output logic [POS_W-1:0]   pos2,
  output logic [NUM_POS-1:0] pos1_oh,
  output logic [NUM_POS-1:0] pos2_oh,
  output logic [HP_W-1:0]    hp1,
  output logic [HP_W-1:0]    hp2,
  output logic [WIN_W-1:0]   wins1,
  output logic [WIN_W-1:0]   wins2,
  output logic               round_over,
  output logic               match_over,
  output logic [1:0]         winner
);
  localparam int RW = $clog2(REGEN_WAIT + 1);
  localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam int PW = (ROUND_PAUSE < 2) ? 1 : $clog2(ROUND_PAUSE);
  localparam logic [POS_W-1:0]   P_MAX  = POS_W'(NUM_POS);
  localparam logic [POS_W-1:0]   P_MIN  = POS_W'(1);
  localparam logic [HP_W-1:0]    H_MAX  = HP_W'(MAX_HP);
  localparam logic [NUM_POS-1:0] OH_MAX = {1'b1, {(NUM_POS-1){1'b0}}};

  typedef enum logic [1:0] {FIGHT, ROUND_END, MATCH_OVER} state_t;

  state_t          state;
  logic [RW-1:0]   rest1, rest2, rest1_n, rest2_n;
  logic [CW-1:0]   cd1, cd2, cd1_n, cd2_n;
  logic [PW-1:0]   pause;
  logic [POS_W-1:0] mv1, mv2, np1, np2;
  logic [HP_W-1:0]  rg1, rg2, nh1, nh2;
  logic [POS_W:0]   gap;
  logic try1, try2, pch1, pch2, kck1, kck2;
  logic near, mid, clash, land1, land2, ko1, ko2;
  logic [WIN_W-1:0] w1_inc, w2_inc;

  function automatic logic [POS_W-1:0] step_out(input logic [POS_W-1:0] p);
    return (p == P_MAX) ? p : p + 1'b1;
  endfunction

  function automatic logic [POS_W-1:0] step_in(input logic [POS_W-1:0] p);
    return (p == P_MIN) ? p : p - 1'b1;
  endfunction

  function automatic logic [NUM_POS-1:0] onehot(input logic [POS_W-1:0] p);
    return {{(NUM_POS-1){1'b0}}, 1'b1} << (p - 1'b1);
  endfunction

  function automatic logic [HP_W-1:0] take_hit(input logic [HP_W-1:0] h, input int dmg);
    return (int'(h) > dmg) ? HP_W'(int'(h) - dmg) : '0;
  endfunction

  always_comb begin
    // P1 "right" and P2 "left" both step toward the centre line
    mv1 = pos1;
    if (act1[1] && !act1[0])      mv1 = step_out(pos1);
    else if (act1[0] && !act1[1]) mv1 = step_in(pos1);
    mv2 = pos2;
    if (act2[0] && !act2[1])      mv2 = step_out(pos2);
    else if (act2[1] && !act2[0]) mv2 = step_in(pos2);

    rest1_n = '0;
    rg1     = hp1;
    if (act1[3] && !(act1[5] || act1[4])) begin
      if (rest1 == RW'(REGEN_WAIT - 1)) rg1 = (hp1 == H_MAX) ? hp1 : hp1 + 1'b1;
      else                              rest1_n = rest1 + 1'b1;
    end
    rest2_n = '0;
    rg2     = hp2;
    if (act2[3] && !(act2[5] || act2[4])) begin
      if (rest2 == RW'(REGEN_WAIT - 1)) rg2 = (hp2 == H_MAX) ? hp2 : hp2 + 1'b1;
      else                              rest2_n = rest2 + 1'b1;
    end

    try1 = !act1[3] && (act1[5] || act1[4]) && (cd1 == '0);
    try2 = !act2[3] && (act2[5] || act2[4]) && (cd2 == '0);
    pch1 = try1 && act1[5];
    kck1 = try1 && !act1[5];
    pch2 = try2 && act2[5];
    kck2 = try2 && !act2[5];
    cd1_n = try1 ? CW'(COOLDOWN) : ((cd1 != '0) ? cd1 - 1'b1 : cd1);
    cd2_n = try2 ? CW'(COOLDOWN) : ((cd2 != '0) ? cd2 - 1'b1 : cd2);

    gap   = {1'b0, mv1} + {1'b0, mv2};
    near  = (gap == (POS_W+1)'(2));
    mid   = (gap == (POS_W+1)'(3));
    clash = (pch1 && pch2 && near) || (kck1 && kck2 && mid);
    land1 = !clash && ((pch1 && near) || (kck1 && (near || mid))) && !act2[2];
    land2 = !clash && ((pch2 && near) || (kck2 && (near || mid))) && !act1[2];

    np1 = clash ? step_out(mv1) : mv1;
    np2 = clash ? step_out(mv2) : mv2;
    nh1 = land2 ? take_hit(rg1, pch2 ? PUNCH_DMG : KICK_DMG) : rg1;
    nh2 = land1 ? take_hit(rg2, pch1 ? PUNCH_DMG : KICK_DMG) : rg2;
    ko1 = (nh1 == '0);
    ko2 = (nh2 == '0);
    w1_inc = wins1 + 1'b1;
    w2_inc = wins2 + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FIGHT;
      pos1       <= P_MAX;
      pos2       <= P_MAX;
      pos1_oh    <= OH_MAX;
      pos2_oh    <= OH_MAX;
      hp1        <= H_MAX;
      hp2        <= H_MAX;
      wins1      <= '0;
      wins2      <= '0;
      rest1      <= '0;
      rest2      <= '0;
      cd1        <= '0;
      cd2        <= '0;
      pause      <= '0;
      round_over <= 1'b0;
      match_over <= 1'b0;
      winner     <= 2'b00;
    end else if (en) begin
      case (state)
        FIGHT: begin
          pos1    <= np1;
          pos2    <= np2;
          pos1_oh <= onehot(np1);
          pos2_oh <= onehot(np2);
          hp1     <= nh1;
          hp2     <= nh2;
          rest1   <= rest1_n;
          rest2   <= rest2_n;
          cd1     <= cd1_n;
          cd2     <= cd2_n;
          if (ko1 && ko2) begin
            state      <= ROUND_END;
            round_over <= 1'b1;
          end else if (ko2) begin
            wins1 <= w1_inc;
            if (w1_inc == WIN_W'(ROUNDS_TO_WIN)) begin
              state      <= MATCH_OVER;
              match_over <= 1'b1;
              winner     <= 2'b01;
            end else begin
              state      <= ROUND_END;
              round_over <= 1'b1;
            end
          end else if (ko1) begin
            wins2 <= w2_inc;
            if (w2_inc == WIN_W'(ROUNDS_TO_WIN)) begin
              state      <= MATCH_OVER;
              match_over <= 1'b1;
              winner     <= 2'b10;
            end else begin
              state      <= ROUND_END;
              round_over <= 1'b1;
            end
          end
        end
        ROUND_END: begin
          if (pause == PW'(ROUND_PAUSE - 1)) begin
            state      <= FIGHT;
            round_over <= 1'b0;
            pause      <= '0;
            pos1       <= P_MAX;
            pos2       <= P_MAX;
            pos1_oh    <= OH_MAX;
            pos2_oh    <= OH_MAX;
            hp1        <= H_MAX;
            hp2        <= H_MAX;
            rest1      <= '0;
            rest2      <= '0;
            cd1        <= '0;
            cd2        <= '0;
          end else begin
            pause <= pause + 1'b1;
          end
        end
        MATCH_OVER: ;
        default: state <= FIGHT;
      endcase
    end
  end

endmodule
